// File: rtl/gpr_pkg.sv
// -----------------------------------------------------------------------------
// gpr_pkg
//   Shared definitions for the general-purpose register file. The core and the
//   register file both import this package, so register geometry and bus types
//   are defined in one place.
//   Buses are numbered MSB-first: bit 0 is the most significant bit.
// -----------------------------------------------------------------------------
package gpr_pkg;

    localparam int GPR_NREGS = 32;  // number of architected GPRs
    localparam int GPR_AW    = 5;   // log2(GPR_NREGS)
    localparam int GPR_DW    = 64;  // register width

    typedef logic [0:GPR_AW-1] gpr_addr_t;
    typedef logic [0:GPR_DW-1] gpr_data_t;

endpackage : gpr_pkg

// File: rtl/gpr_rd_port.sv
// -----------------------------------------------------------------------------
// gpr_rd_port
//   One synchronous read port of the GPR file: a registered mux over the
//   storage array with an enable that holds the last value when deasserted.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset, clears o_data
//   i_en     in   read enable; 0 = hold previous o_data
//   i_addr   in   register index, sampled on the rising edge
//   i_mem    in   current contents of the storage array
//   o_data   out  registered read data, one cycle after the request
// -----------------------------------------------------------------------------
module gpr_rd_port
    import gpr_pkg::*;
#(
    parameter int NREGS = GPR_NREGS,
    parameter int AW    = GPR_AW,
    parameter int DW    = GPR_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic [0:AW-1] i_addr,
    input  logic [0:DW-1] i_mem [NREGS],
    output logic [0:DW-1] o_data
);

    logic [0:DW-1] r_data;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values of its inputs, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_en) begin
            // i_mem holds pre-edge contents, giving read-before-write.
            r_data <= i_mem[i_addr];
        end
    end

    assign o_data = r_data;

endmodule : gpr_rd_port

// File: rtl/gpr_regs.sv
// -----------------------------------------------------------------------------
// gpr_regs
//   32 x 64-bit general-purpose register file: two registered read ports and
//   two write ports. No internal forwarding; a read on the same edge as a
//   write to the same register returns the old contents. When both write
//   ports target one register on the same edge, port 1 wins.
//
// Ports
//   clk          in   system clock, all updates on the rising edge
//   rst_n        in   asynchronous active-low reset; clears array and outputs
//   readEn0/1    in   read port enable (0 = hold readDataN)
//   readAddr0/1  in   read port register index
//   readData0/1  out  registered read data, 1-cycle latency
//   writeEn0/1   in   write port enable
//   writeAddr0/1 in   write port register index
//   writeData0/1 in   write port data
// -----------------------------------------------------------------------------
module gpr_regs
    import gpr_pkg::*;
#(
    parameter int NREGS = GPR_NREGS,
    parameter int AW    = GPR_AW,
    parameter int DW    = GPR_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          readEn0,
    input  logic [0:AW-1] readAddr0,
    output logic [0:DW-1] readData0,
    input  logic          readEn1,
    input  logic [0:AW-1] readAddr1,
    output logic [0:DW-1] readData1,
    input  logic          writeEn0,
    input  logic [0:AW-1] writeAddr0,
    input  logic [0:DW-1] writeData0,
    input  logic          writeEn1,
    input  logic [0:AW-1] writeAddr1,
    input  logic [0:DW-1] writeData1
);

    logic [0:DW-1] r_mem [NREGS];

    // NOTE: the array is built from flops, so every entry can be cleared by
    // the async reset; a RAM macro would not allow this.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // Port 1 is applied last so it overrides port 0 on an address clash.
            if (writeEn0) begin
                r_mem[writeAddr0] <= writeData0;
            end
            if (writeEn1) begin
                r_mem[writeAddr1] <= writeData1;
            end
        end
    end

    gpr_rd_port #(
        .NREGS (NREGS),
        .AW    (AW),
        .DW    (DW)
    ) u_rd_port0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (readEn0),
        .i_addr (readAddr0),
        .i_mem  (r_mem),
        .o_data (readData0)
    );

    gpr_rd_port #(
        .NREGS (NREGS),
        .AW    (AW),
        .DW    (DW)
    ) u_rd_port1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (readEn1),
        .i_addr (readAddr1),
        .i_mem  (r_mem),
        .o_data (readData1)
    );

endmodule : gpr_regs

// File: tb/tb_gpr_regs.sv
// -----------------------------------------------------------------------------
// tb_gpr_regs
//   Directed bench for gpr_regs. Inputs change on the falling edge; a small
//   architectural model computes expected read data when a request is driven
//   and pushes it to a scoreboard, which is popped and compared 1 time unit
//   after the following rising edge.
// -----------------------------------------------------------------------------
module tb_gpr_regs;
    import gpr_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      readEn0, readEn1, writeEn0, writeEn1;
    gpr_addr_t readAddr0, readAddr1, writeAddr0, writeAddr1;
    gpr_data_t writeData0, writeData1;
    gpr_data_t readData0, readData1;

    always #5 clk = ~clk;

    gpr_regs dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .readEn0    (readEn0),
        .readAddr0  (readAddr0),
        .readData0  (readData0),
        .readEn1    (readEn1),
        .readAddr1  (readAddr1),
        .readData1  (readData1),
        .writeEn0   (writeEn0),
        .writeAddr0 (writeAddr0),
        .writeData0 (writeData0),
        .writeEn1   (writeEn1),
        .writeAddr1 (writeAddr1),
        .writeData1 (writeData1)
    );

    typedef struct {
        bit        port;
        gpr_data_t val;
        string     tag;
    } sb_t;

    sb_t       sb[$];
    gpr_data_t model [GPR_NREGS];
    gpr_data_t exp0, exp1;
    int        errors = 0;
    int        checks = 0;

    localparam gpr_data_t SWEEP_K = 64'h0101_0101_0101_0101;

    task automatic check(input string tag, input gpr_data_t obs, input gpr_data_t expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        readEn0  = 1'b0;
        readEn1  = 1'b0;
        writeEn0 = 1'b0;
        writeEn1 = 1'b0;
    endtask

    task automatic rd0(input int a);
        readEn0 = 1'b1; readAddr0 = gpr_addr_t'(a);
    endtask

    task automatic rd1(input int a);
        readEn1 = 1'b1; readAddr1 = gpr_addr_t'(a);
    endtask

    task automatic wr0(input int a, input gpr_data_t d);
        writeEn0 = 1'b1; writeAddr0 = gpr_addr_t'(a); writeData0 = d;
    endtask

    task automatic wr1(input int a, input gpr_data_t d);
        writeEn1 = 1'b1; writeAddr1 = gpr_addr_t'(a); writeData1 = d;
    endtask

    task automatic clear_model();
        for (int i = 0; i < GPR_NREGS; i++) model[i] = '0;
        exp0 = '0;
        exp1 = '0;
    endtask

    // One clock with the currently driven inputs. Reads sample the model
    // before this edge's writes are applied (read-before-write), and port 1
    // is applied after port 0.
    task automatic cycle(input string tag);
        sb_t e;
        if (readEn0) exp0 = model[readAddr0];
        if (readEn1) exp1 = model[readAddr1];
        if (writeEn0) model[writeAddr0] = writeData0;
        if (writeEn1) model[writeAddr1] = writeData1;
        sb.push_back('{1'b0, exp0, tag});
        sb.push_back('{1'b1, exp1, tag});
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port) check({e.tag, "/rd1"}, readData1, e.val);
            else        check({e.tag, "/rd0"}, readData0, e.val);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        idle();
        readAddr0  = '0;
        readAddr1  = '0;
        writeAddr0 = '0;
        writeAddr1 = '0;
        writeData0 = '0;
        writeData1 = '0;
        clear_model();

        // Reset state
        repeat (2) @(negedge clk);
        check("reset/rd0", readData0, '0);
        check("reset/rd1", readData1, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write via port 0, read via port 1
        idle(); wr0(3, 64'h48);                   cycle("basic_wr");
        idle(); rd1(3);                           cycle("basic_rd");

        // Read/write collision: old value returned, new one next read
        idle(); wr0(7, 64'h5);                    cycle("coll_init");
        idle(); wr0(7, 64'h1111); rd0(7);         cycle("coll_same_edge");
        idle(); rd0(7);                           cycle("coll_next");

        // Dual write, same address (port 1 wins), then distinct addresses
        idle(); wr0(9, 64'hAAAA); wr1(9, 64'hBBBB); cycle("dual_same_wr");
        idle(); rd0(9); rd1(9);                   cycle("dual_same_rd");
        idle(); wr0(10, 64'hC0DE_0010); wr1(11, 64'hC0DE_0011); cycle("dual_diff_wr");
        idle(); rd0(10); rd1(11);                 cycle("dual_diff_rd");

        // Enable hold: address changes while disabled must not disturb output
        idle(); rd0(3);                           cycle("hold_load");
        idle(); readAddr0 = gpr_addr_t'(5);
        repeat (3)                                cycle("hold");

        // Asynchronous reset mid-run
        idle(); wr0(5, 64'hDEAD);                 cycle("rst_wr");
        idle(); rd0(5); rd1(5);                   cycle("rst_pre");
        #2 rst_n = 1'b0;
        #1;
        check("rst_async/rd0", readData0, '0);
        check("rst_async/rd1", readData1, '0);
        idle(); wr0(6, 64'hFF); rd0(3);           // must be ignored while in reset
        @(posedge clk);
        #1;
        check("rst_hold/rd0", readData0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        idle(); rd0(5); rd1(6);                   cycle("rst_after");
        idle(); rd0(3);                           cycle("rst_after_r3");

        // Full sweep: alternate write ports, then read all on both ports
        for (int i = 0; i < GPR_NREGS; i++) begin
            idle();
            if (i % 2 == 0) wr0(i, gpr_data_t'(i) * SWEEP_K);
            else            wr1(i, gpr_data_t'(i) * SWEEP_K);
            cycle("sweep_wr");
        end
        for (int i = 0; i < GPR_NREGS; i++) begin
            idle(); rd0(i); rd1(GPR_NREGS - 1 - i);
            cycle("sweep_rd");
        end
        idle(); rd0(17); rd1(17);                 cycle("same_addr_rd");
        idle(); rd0(0);  rd1(31);                 cycle("sweep_edges");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_gpr_regs
